obi_sram_responder: RTL and testbench

- OBI responder (memory slave) that serves one master port of the CGRA memory-node array: input and output memory nodes.
- Word-addressed SRAM with byte enables, configurable grant wait states, fixed read latency and an outstanding-transaction limit.
- Used as the memory-side counterpart in block- and subsystem-level benches, and as a scratchpad behind the bus.
- stall_i allows the bench to inject back-pressure.

---
 rtl/obi_sram_responder.sv | 161 ++++++++++++++++
 tb/tb_obi_sram_responder.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : obi_sram_responder
// Purpose  : OBI memory responder, byte-enabled word SRAM with grant wait
//            states, fixed read latency and an outstanding-transaction limit.
// Revision : 1.0
// ============================================================================

package obi_sram_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_sram_responder
    import obi_sram_pkg::*;
#(
    parameter int          NUM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          GNT_LATENCY     = 0,
    parameter int          RVALID_LATENCY  = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  obi_req_t    obi_req_i,
    output obi_resp_t   obi_resp_o,
    input  logic        stall_i,
    output logic [15:0] err_count_o
);
    localparam int c_aw = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int c_ow = $clog2(MAX_OUTSTANDING + 1);

    logic [30:0]     w_diff;
    logic            w_in_range;
    logic [c_aw-1:0] w_idx;
    logic            w_wait_ok;
    logic            w_gnt;
    logic            w_rsp;
    logic [31:0]     w_rsp_data;
    logic            w_unused;

    logic [c_ow-1:0] r_outst;
    logic [15:0]     r_err;
    logic [31:0]     r_mem [NUM_WORDS];
    logic            r_pv  [RVALID_LATENCY];
    logic [31:0]     r_pd  [RVALID_LATENCY];

    // Word-granular subtraction; the borrow bit flags addresses below the base.
    assign w_diff     = {1'b0, obi_req_i.addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign w_in_range = !w_diff[30] && ({2'b00, w_diff[29:0]} < 32'(NUM_WORDS));
    assign w_idx      = w_diff[c_aw-1:0];
    assign w_unused   = ^{obi_req_i.addr[1:0]};

    generate
        if (GNT_LATENCY == 0) begin : g_no_wait
            assign w_wait_ok = 1'b1;
        end else begin : g_wait
            localparam int c_wcw = $clog2(GNT_LATENCY + 1);
            logic [c_wcw-1:0] r_wcnt;

            always_ff @(posedge clk_i) begin
                if (rst_i || !obi_req_i.req || w_gnt) begin
                    r_wcnt <= '0;
                end else if (r_wcnt < c_wcw'(GNT_LATENCY)) begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end

            assign w_wait_ok = (r_wcnt >= c_wcw'(GNT_LATENCY));
        end
    endgenerate

    assign w_gnt = obi_req_i.req && w_wait_ok && !stall_i && !rst_i &&
                   (r_outst < c_ow'(MAX_OUTSTANDING));
    assign w_rsp = r_pv[RVALID_LATENCY-1];

    always_comb begin
        w_rsp_data = 32'h0000_0000;
        if (!obi_req_i.we) begin
            w_rsp_data = w_in_range ? r_mem[w_idx] : 32'hDEAD_BEEF;
        end
    end

    // SRAM array carries no reset so contents survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (w_gnt && obi_req_i.we && w_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (obi_req_i.be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= obi_req_i.wdata[8*k +: 8];
                end
            end
        end
    end

    // Response delay line; data stages only advance with a valid entry so the
    // last stage holds the most recent rdata while rvalid is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 32'h0000_0000;
            end
        end else begin
            r_pv[0] <= w_gnt;
            if (w_gnt) begin
                r_pd[0] <= w_rsp_data;
            end
            for (int i = 1; i < RVALID_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outst <= '0;
            r_err   <= 16'h0000;
        end else begin
            case ({w_gnt, w_rsp})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
            if (w_gnt && !w_in_range && (r_err != 16'hFFFF)) begin
                r_err <= r_err + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_rsp && !w_gnt && (r_outst == '0)));
            assert (!(w_gnt && !w_rsp && (r_outst == c_ow'(MAX_OUTSTANDING))));
        end
    end

    always_comb begin
        obi_resp_o        = '0;
        obi_resp_o.gnt    = w_gnt;
        obi_resp_o.rvalid = w_rsp;
        obi_resp_o.rdata  = r_pd[RVALID_LATENCY-1];
    end

    assign err_count_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_obi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_sram_responder
// Purpose  : Self-checking bench for obi_sram_responder, three configurations.
// Revision : 1.0
// ============================================================================
module tb_obi_sram_responder;
    import obi_sram_pkg::*;

    localparam int          NW   = 256;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int GL [3] = '{0, 3, 0};
    localparam int RL [3] = '{1, 1, 4};
    localparam int MO [3] = '{2, 2, 2};

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    obi_req_t    req   [3];
    obi_resp_t   rsp   [3];
    logic        stall [3];
    logic [15:0] errc  [3];
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            obi_sram_responder #(
                .NUM_WORDS      (NW),
                .BASE_ADDR      (BASE),
                .GNT_LATENCY    (GL[g]),
                .RVALID_LATENCY (RL[g]),
                .MAX_OUTSTANDING(MO[g])
            ) u_dut (
                .clk_i      (clk),
                .rst_i      (rst),
                .obi_req_i  (req[g]),
                .obi_resp_o (rsp[g]),
                .stall_i    (stall[g]),
                .err_count_o(errc[g])
            );
        end
    endgenerate

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            req[k]   = '0;
            stall[k] = 1'b0;
        end
    endtask

    task automatic drive(input int k, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        req[k].req   = 1'b1;
        req[k].we    = we;
        req[k].be    = be;
        req[k].addr  = a;
        req[k].wdata = wd;
    endtask

    // Single transaction with bounded waits; ok=0 if grant or response never came.
    task automatic xact(input int k, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit ok);
        drive(k, we, be, a, wd);
        ok = 1'b0;
        rd = 32'h0;
        for (int t = 0; t < 32 && !ok; t++) begin
            @(negedge clk);
            ok = rsp[k].gnt;
            tick();
        end
        req[k].req = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int t = 0; t < 16 && !ok; t++) begin
                @(negedge clk);
                if (rsp[k].rvalid) begin
                    ok = 1'b1;
                    rd = rsp[k].rdata;
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 4'hF, BASE, 32'h0);
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (rsp[k].gnt !== 1'b0 || rsp[k].rvalid !== 1'b0 || errc[k] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL reset_outputs[%0d]: gnt=%0b rvalid=%0b err=%0d, expected 0/0/0",
                             k, rsp[k].gnt, rsp[k].rvalid, errc[k]);
                end
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp[0].gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_gnt: got %0b expected 1", rsp[0].gnt);
        end
        n_tests++;
        if (rsp[1].gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_waitstate_gnt: got %0b expected 0", rsp[1].gnt);
        end
        tick();
        idle_all();
        repeat (6) tick();
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 4'hF, BASE + 32'd8, 32'h1234_5678);
        @(negedge clk);
        n_tests++;
        if (rsp[0].gnt !== 1'b1) begin
            n_fail++; $display("FAIL wr1_gnt: got %0b expected 1", rsp[0].gnt);
        end
        tick();
        drive(0, 1'b1, 4'b0010, BASE + 32'd8, 32'h0000_AB00);
        @(negedge clk);
        n_tests++;
        if (rsp[0].gnt !== 1'b1 || rsp[0].rvalid !== 1'b1 || rsp[0].rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL wr1_rsp: gnt=%0b rvalid=%0b rdata=%h, expected 1/1/00000000",
                     rsp[0].gnt, rsp[0].rvalid, rsp[0].rdata);
        end
        tick();
        drive(0, 1'b0, 4'hF, BASE + 32'd8, 32'h0);
        @(negedge clk);
        n_tests++;
        if (rsp[0].gnt !== 1'b1 || rsp[0].rvalid !== 1'b1 || rsp[0].rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL wr2_rsp: gnt=%0b rvalid=%0b rdata=%h, expected 1/1/00000000",
                     rsp[0].gnt, rsp[0].rvalid, rsp[0].rdata);
        end
        tick();
        idle_all();
        @(negedge clk);
        n_tests++;
        if (rsp[0].rvalid !== 1'b1 || rsp[0].rdata !== 32'h1234_AB78) begin
            n_fail++;
            $display("FAIL rd_rsp: rvalid=%0b rdata=%h, expected 1/1234ab78",
                     rsp[0].rvalid, rsp[0].rdata);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (rsp[0].rvalid !== 1'b0 || rsp[0].rdata !== 32'h1234_AB78) begin
            n_fail++;
            $display("FAIL rd_hold: rvalid=%0b rdata=%h, expected 0/1234ab78",
                     rsp[0].rvalid, rsp[0].rdata);
        end
        tick();
    endtask

    task automatic test_wait_states();
        drive(1, 1'b0, 4'hF, BASE, 32'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (rsp[1].gnt !== ((c == 3) || (c == 7)) || rsp[1].rvalid !== (c == 4)) begin
                n_fail++;
                $display("FAIL wait_gnt cycle %0d: gnt=%0b rvalid=%0b, expected %0b/%0b",
                         c, rsp[1].gnt, rsp[1].rvalid, (c == 3) || (c == 7), c == 4);
            end
            tick();
        end
        idle_all();
        repeat (6) tick();
    endtask

    task automatic test_outstanding();
        logic [31:0] data [6];
        logic [31:0] rd;
        bit          ok;
        int          idx = 0;
        int          rv  = 0;
        for (int i = 0; i < 6; i++) begin
            data[i] = $urandom;
            xact(2, 1'b1, 4'hF, BASE + 32'h40 + 32'(4 * i), data[i], rd, ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL outst_setup_write %0d: timeout", i);
            end
        end
        repeat (4) tick();
        // A slot freed by rvalid only becomes usable in the following cycle.
        for (int c = 0; c < 18; c++) begin
            if (idx < 6) drive(2, 1'b0, 4'hF, BASE + 32'h40 + 32'(4 * idx), 32'h0);
            else req[2].req = 1'b0;
            @(negedge clk);
            n_tests++;
            if (rsp[2].gnt !== (c inside {0, 1, 5, 6, 10, 11}) ||
                rsp[2].rvalid !== (c inside {4, 5, 9, 10, 14, 15})) begin
                n_fail++;
                $display("FAIL outst_timing cycle %0d: gnt=%0b rvalid=%0b, expected %0b/%0b", c,
                         rsp[2].gnt, rsp[2].rvalid, c inside {0, 1, 5, 6, 10, 11},
                         c inside {4, 5, 9, 10, 14, 15});
            end
            if (c inside {4, 5, 9, 10, 14, 15}) begin
                n_tests++;
                if (rsp[2].rdata !== data[rv]) begin
                    n_fail++;
                    $display("FAIL outst_rdata %0d: got %h expected %h", rv, rsp[2].rdata, data[rv]);
                end
                rv++;
            end
            if (rsp[2].gnt) idx++;
            tick();
        end
        idle_all();
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        bit          ok;
        xact(0, 1'b1, 4'hF, BASE, 32'hCAFE_0001, rd, ok);
        xact(0, 1'b1, 4'hF, BASE + 32'(4 * (NW - 1)), 32'h5A5A_0FF0, rd, ok);
        n_tests++;
        if (errc[0] !== 16'd0) begin
            n_fail++; $display("FAIL oor_err_initial: got %0d expected 0", errc[0]);
        end
        xact(0, 1'b0, 4'hF, BASE + 32'(4 * NW), 32'h0, rd, ok);
        n_tests++;
        if (!ok || rd !== 32'hDEAD_BEEF || errc[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL oor_read: ok=%0b rdata=%h err=%0d, expected 1/deadbeef/1", ok, rd, errc[0]);
        end
        xact(0, 1'b1, 4'hF, BASE - 32'd4, 32'hFFFF_FFFF, rd, ok);
        n_tests++;
        if (!ok || rd !== 32'h0 || errc[0] !== 16'd2) begin
            n_fail++;
            $display("FAIL oor_write: ok=%0b rdata=%h err=%0d, expected 1/00000000/2", ok, rd, errc[0]);
        end
        xact(0, 1'b0, 4'hF, BASE, 32'h0, rd, ok);
        n_tests++;
        if (!ok || rd !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL oor_word0_intact: got %h expected cafe0001", rd);
        end
        xact(0, 1'b0, 4'hF, BASE + 32'(4 * (NW - 1)) + 32'd3, 32'h0, rd, ok);
        n_tests++;
        if (!ok || rd !== 32'h5A5A_0FF0 || errc[0] !== 16'd2) begin
            n_fail++;
            $display("FAIL last_word_read: rdata=%h err=%0d, expected 5a5a0ff0/2", rd, errc[0]);
        end
    endtask

    task automatic test_stall_reset();
        drive(2, 1'b0, 4'hF, BASE + 32'h40, 32'h0);
        stall[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (rsp[2].gnt !== 1'b0) begin
                n_fail++; $display("FAIL stall_gnt cycle %0d: got %0b expected 0", c, rsp[2].gnt);
            end
            tick();
        end
        stall[2] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp[2].gnt !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_gnt: got %0b expected 1", rsp[2].gnt);
        end
        tick();
        req[2].req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (rsp[2].rvalid !== 1'b0) begin
                n_fail++; $display("FAIL dropped_rvalid cycle %0d: got %0b expected 0", c, rsp[2].rvalid);
            end
            tick();
        end
        n_tests++;
        if (errc[0] !== 16'd0) begin
            n_fail++; $display("FAIL reset_err_clear: got %0d expected 0", errc[0]);
        end
        for (int i = 0; i < 2; i++) begin
            drive(2, 1'b0, 4'hF, BASE + 32'h40 + 32'(4 * i), 32'h0);
            @(negedge clk);
            n_tests++;
            if (rsp[2].gnt !== 1'b1) begin
                n_fail++; $display("FAIL reset_outst_clear %0d: gnt=%0b expected 1", i, rsp[2].gnt);
            end
            tick();
        end
        idle_all();
        repeat (8) tick();
    endtask

    task automatic test_random(input int k, input int ncyc);
        exp_t        q[$];
        logic [31:0] mm    [8];
        bit          known [8];
        logic [31:0] last = 32'h0;
        logic [31:0] a;
        logic [31:0] d;
        int          held = 0;
        int          errm = 0;
        int          w;
        bit          pend = 1'b0;
        bit          exp_g;
        bit          exp_rv;
        for (int i = 0; i < 8; i++) known[i] = 1'b0;
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (!pend) begin
                if ($urandom_range(3) != 0 && c < ncyc - 20) begin
                    if ($urandom_range(9) == 0) begin
                        if ($urandom_range(1) == 1) a = BASE + 32'(4 * NW) + 32'(4 * $urandom_range(100));
                        else a = BASE - 32'd4 - 32'(4 * $urandom_range(100));
                        drive(k, 1'($urandom_range(1)), 4'($urandom_range(15)), a, $urandom);
                    end else begin
                        w = $urandom_range(7);
                        a = BASE + 32'(4 * (16 + w)) + 32'($urandom_range(3));
                        if (!known[w]) drive(k, 1'b1, 4'hF, a, $urandom);
                        else drive(k, 1'($urandom_range(1)), 4'($urandom_range(15)), a, $urandom);
                    end
                    pend = 1'b1;
                end else begin
                    req[k].req = 1'b0;
                end
            end
            stall[k] = (c < ncyc - 20) && ($urandom_range(4) == 0);
            @(negedge clk);
            exp_g  = req[k].req && (held >= GL[k]) && !stall[k] && (q.size() < MO[k]);
            exp_rv = (q.size() > 0) && (q[0].due == c);
            if (exp_rv) last = q.pop_front().d;
            n_tests++;
            if (rsp[k].gnt !== exp_g || rsp[k].rvalid !== exp_rv || rsp[k].rdata !== last ||
                errc[k] !== 16'(errm)) begin
                n_fail++;
                $display("FAIL rand[%0d] cycle %0d: gnt=%0b rvalid=%0b rdata=%h err=%0d, expected %0b/%0b/%h/%0d",
                         k, c, rsp[k].gnt, rsp[k].rvalid, rsp[k].rdata, errc[k],
                         exp_g, exp_rv, last, errm);
            end
            if (exp_g) begin
                a = req[k].addr;
                if (a >= BASE && (a - BASE) / 4 < NW) begin
                    w = int'((a - BASE) / 4) - 16;
                    if (req[k].we) begin
                        for (int b = 0; b < 4; b++)
                            if (req[k].be[b]) mm[w][8*b +: 8] = req[k].wdata[8*b +: 8];
                        if (req[k].be == 4'hF) known[w] = 1'b1;
                        d = 32'h0;
                    end else begin
                        d = mm[w];
                    end
                end else begin
                    d = req[k].we ? 32'h0 : 32'hDEAD_BEEF;
                    errm++;
                end
                q.push_back('{c + RL[k], d});
                pend = 1'b0;
            end
            held = (req[k].req && !exp_g) ? held + 1 : 0;
            tick();
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL rand[%0d] drain: %0d responses missing, expected 0", k, q.size());
        end
        idle_all();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_all();
        test_reset();
        test_write_read();
        test_wait_states();
        test_outstanding();
        test_out_of_range();
        test_stall_reset();
        for (int k = 0; k < 3; k++) test_random(k, 300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
